i2s_rx: RTL and testbench



---
 rtl/i2s_rx_if.sv | 42 ++++
 rtl/i2s_rx.sv | 188 ++++++++++++++++++
 tb/tb_i2s_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2s_rx_if
//  Purpose  : Pair-delivery bus between the I2S receiver and its consumer:
//             left/right sample words, valid/ready handshake, sticky overrun
//             flag and its clear strobe.
//  Revision : 1.0  initial release
// ============================================================================
interface i2s_rx_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH-1:0] L_DATA;
    logic [WIDTH-1:0] R_DATA;
    logic             VALID;
    logic             READY;
    logic             OVERRUN;
    logic             CLR_OVR;

    // Receiver side: produces the pair and the status flag.
    modport master (
        output L_DATA,
        output R_DATA,
        output VALID,
        output OVERRUN,
        input  READY,
        input  CLR_OVR
    );

    // Consumer side: accepts pairs and clears the overrun flag.
    modport slave (
        input  L_DATA,
        input  R_DATA,
        input  VALID,
        input  OVERRUN,
        output READY,
        output CLR_OVR
    );

endinterface
`default_nettype wire

// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2s_rx
//  Purpose  : I2S slave receiver. Synchronizes the asynchronous board bit
//             clock, word select and data into CLK, deserializes MSB-first
//             words (left-justified / truncated to WIDTH), aligns frames so
//             that a pair always starts at left, and publishes each L/R pair
//             on a valid/ready handshake with a sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
module i2s_rx #(
    parameter int WIDTH = 16
) (
    input  wire logic  CLK,
    input  wire logic  n_RST,
    input  wire logic  I2S_SCLK,
    input  wire logic  I2S_WS,
    input  wire logic  I2S_SD,
    i2s_rx_if.master   bus
);

    localparam int               CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    WIDTH_CNT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MSB_MASK  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        SYNC_R = 2'd1,
        SYNC_L = 2'd2,
        GOT_L  = 2'd3
    } state_t;

    // Synchronizer chains; index 0 is the first stage, SCLK has a third
    // stage purely for edge detection.
    logic [2:0]       sclk_sync_q, sclk_sync_d;
    logic [1:0]       ws_sync_q,   ws_sync_d;
    logic [1:0]       sd_sync_q,   sd_sync_d;

    // Deserializer
    logic             ws_prev_q,   ws_prev_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] word_q,      word_d;
    logic             word_end_q,  word_end_d;
    logic             new_ch_q,    new_ch_d;

    // Framing FSM and output registers
    state_t           state_q,     state_d;
    logic [WIDTH-1:0] hold_q,      hold_d;
    logic [WIDTH-1:0] l_data_q,    l_data_d;
    logic [WIDTH-1:0] r_data_q,    r_data_d;
    logic             valid_q,     valid_d;
    logic             overrun_q,   overrun_d;

    logic             rise;
    logic             ws_cur;
    logic             sd_cur;
    logic [WIDTH-1:0] bit_word;
    logic             publish;
    logic             accept;

    assign rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ws_cur = ws_sync_q[1];
    assign sd_cur = sd_sync_q[1];
    assign accept = valid_q & bus.READY;

    // Synchronize the board lines and assemble words on each SCLK rise.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], I2S_SCLK};
        ws_sync_d   = {ws_sync_q[0], I2S_WS};
        sd_sync_d   = {sd_sync_q[0], I2S_SD};

        ws_prev_d   = ws_prev_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        word_end_d  = 1'b0;
        new_ch_d    = new_ch_q;

        // Bits land directly at their left-justified position, so a short
        // word is already zero-padded and bits past WIDTH are dropped.
        bit_word = shift_q;
        if (cnt_q < WIDTH_CNT && sd_cur) begin
            bit_word = shift_q | (MSB_MASK >> cnt_q);
        end

        if (rise) begin
            ws_prev_d = ws_cur;
            if (ws_cur != ws_prev_q) begin
                // This rise carries the LSB of the word owned by ws_prev.
                word_d     = bit_word;
                word_end_d = 1'b1;
                new_ch_d   = ws_cur;
                shift_d    = '0;
                cnt_d      = '0;
            end else begin
                shift_d = bit_word;
                if (cnt_q != WIDTH_CNT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Frame alignment: discard words until a clean left word begins.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        publish = 1'b0;
        if (word_end_q) begin
            case (state_q)
                SEEK:    state_d = new_ch_q ? SYNC_R : SYNC_L;
                SYNC_R:  state_d = SYNC_L;
                SYNC_L: begin
                    hold_d  = word_q;
                    state_d = GOT_L;
                end
                GOT_L: begin
                    publish = 1'b1;
                    state_d = SYNC_L;
                end
                default: state_d = SEEK;
            endcase
        end
    end

    // Handshake and overrun: newest pair always wins; a same-cycle accept
    // consumes the old pair so no overrun is flagged.
    always_comb begin
        l_data_d  = l_data_q;
        r_data_d  = r_data_q;
        valid_d   = valid_q & ~accept;
        overrun_d = overrun_q & ~bus.CLR_OVR;
        if (publish) begin
            l_data_d = hold_q;
            r_data_d = word_q;
            valid_d  = 1'b1;
            if (valid_q && !bus.READY) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge n_RST) begin
        if (!n_RST) begin
            sclk_sync_q <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            ws_prev_q   <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            word_end_q  <= 1'b0;
            new_ch_q    <= 1'b0;
            state_q     <= SEEK;
            hold_q      <= '0;
            l_data_q    <= '0;
            r_data_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ws_sync_q   <= ws_sync_d;
            sd_sync_q   <= sd_sync_d;
            ws_prev_q   <= ws_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            word_end_q  <= word_end_d;
            new_ch_q    <= new_ch_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            l_data_q    <= l_data_d;
            r_data_q    <= r_data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.L_DATA  = l_data_q;
    assign bus.R_DATA  = r_data_q;
    assign bus.VALID   = valid_q;
    assign bus.OVERRUN = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_rx
//  Purpose  : Self-checking bench for i2s_rx. Drives I2S frames, queues the
//             pairs that must appear and compares them as they are accepted.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2s_rx;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic sclk    = 1'b0;
    logic ws      = 1'b0;
    logic sd      = 1'b0;

    i2s_rx_if #(.WIDTH(16)) bus ();

    i2s_rx #(.WIDTH(16)) dut (
        .CLK      (clk),
        .n_RST    (rst_n),
        .I2S_SCLK (sclk),
        .I2S_WS   (ws),
        .I2S_SD   (sd),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One serial bit: data set on the falling edge, 8 CLK low, 8 CLK high.
    task automatic send_bit(input logic w, input logic d);
        ws = w;
        sd = d;
        repeat (8) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (8) @(posedge clk);
        #1 sclk = 1'b0;
    endtask

    // WS switches one bit early: the LSB goes out with the next channel.
    task automatic send_word(input logic ch, input logic [31:0] data, input int n, input logic next_ch);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit((i == 0) ? next_ch : ch, data[i]);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                              input logic push, input logic [15:0] el, input logic [15:0] er);
        if (push) exp_q.push_back({el, er});
        send_word(1'b0, l, n, 1'b1);
        send_word(1'b1, r, n, 1'b0);
    endtask

    // Scoreboard: every accepted pair must be the oldest expected one.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (rst_n && bus.VALID && bus.READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pair", 32'(bus.VALID), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("L_DATA", 32'(bus.L_DATA), 32'(e[31:16]));
                check("R_DATA", 32'(bus.R_DATA), 32'(e[15:0]));
            end
        end
    end

    initial begin
        logic [15:0] part;
        bus.READY   = 1'b1;
        bus.CLR_OVR = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_L",   32'(bus.L_DATA),  32'(0));
        check("rst_R",   32'(bus.R_DATA),  32'(0));
        check("rst_VAL", 32'(bus.VALID),   32'(0));
        check("rst_OVR", 32'(bus.OVERRUN), 32'(0));
        rst_n = 1'b1;

        // Basic: first frame consumed by alignment, then one pair per frame
        send_frame(32'h1234, 32'hABCD, 16, 1'b0, 16'h0, 16'h0);
        send_frame(32'h1234, 32'hABCD, 16, 1'b1, 16'h1234, 16'hABCD);
        send_frame(32'h1234, 32'hABCD, 16, 1'b1, 16'h1234, 16'hABCD);
        @(negedge clk);
        check("basic_OVR", 32'(bus.OVERRUN), 32'(0));
        check("basic_VAL", 32'(bus.VALID),   32'(0));

        // Justify short words, truncate long words
        send_frame(32'hFED,    32'h001,    12, 1'b1, 16'hFED0, 16'h0010);
        send_frame(32'h876543, 32'h13579B, 24, 1'b1, 16'h8765, 16'h1357);

        // Backpressure: two pairs with no accept, newest survives
        @(posedge clk); #1 bus.READY = 1'b0;
        send_frame(32'h1111, 32'h2222, 16, 1'b0, 16'h0, 16'h0);
        send_frame(32'h3333, 32'h4444, 16, 1'b1, 16'h3333, 16'h4444);
        @(negedge clk);
        check("bp_VAL", 32'(bus.VALID),   32'(1));
        check("bp_OVR", 32'(bus.OVERRUN), 32'(1));
        check("bp_L",   32'(bus.L_DATA),  32'h3333);
        @(posedge clk); #1 bus.READY = 1'b1; bus.CLR_OVR = 1'b1;
        @(posedge clk); #1 bus.CLR_OVR = 1'b0;
        @(negedge clk);
        check("clr_VAL", 32'(bus.VALID),   32'(0));
        check("clr_OVR", 32'(bus.OVERRUN), 32'(0));

        // Start on right: the stray right word must never be published
        @(posedge clk); #1 rst_n = 1'b0; ws = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(1'b1, 32'h5A5A, 16, 1'b0);
        send_frame(32'hCAFE, 32'hBEEF, 16, 1'b1, 16'hCAFE, 16'hBEEF);
        send_frame(32'h0246, 32'h8ACE, 16, 1'b1, 16'h0246, 16'h8ACE);

        // Mid-word reset during left bit 7
        part = 16'hA5C3;
        for (int i = 15; i >= 8; i--) send_bit(1'b0, part[i]);
        ws = 1'b0;
        sd = part[7];
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_L",   32'(bus.L_DATA),  32'(0));
        check("mrst_R",   32'(bus.R_DATA),  32'(0));
        check("mrst_VAL", 32'(bus.VALID),   32'(0));
        check("mrst_OVR", 32'(bus.OVERRUN), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(32'h7777, 32'h8888, 16, 1'b0, 16'h0, 16'h0);
        send_frame(32'h0F0F, 32'hF0F0, 16, 1'b1, 16'h0F0F, 16'hF0F0);

        repeat (20) @(posedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
